// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences one scan chain through load, functional capture and unload into a result register
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 clr,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 so,
    output logic                 se,
    output logic                 si,
    output logic                 chain_rn,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result_out
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CAPTURE, UNLOAD, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CHAIN_LEN-1:0] shadow, shadow_n, result_n, sel;
    logic si_n;
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        result_n = result_out;
        sel      = CHAIN_LEN'(1) << (LAST - cnt);
        case (state)
            IDLE: if (start) begin
                state_n  = clr ? CLEAR : LOAD;
                shadow_n = pattern_in;
            end
            CLEAR:   state_n = LOAD;
            LOAD:    state_n = cnt == LAST ? CAPTURE : LOAD;
            CAPTURE: state_n = UNLOAD;
            UNLOAD: begin
                result_n = (result_out & ~sel) | ({CHAIN_LEN{so}} & sel);
                state_n  = cnt == LAST ? DONE : UNLOAD;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n == state && (state == LOAD || state == UNLOAD)) ? cnt + CNT_W'(1) : '0;
        si_n  = state_n == LOAD && |(shadow_n & (CHAIN_LEN'(1) << (LAST - cnt_n)));
    end
    // chain controls are registered from next-state values so they line up with the state they belong to
    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            result_out <= '0;
            se         <= 1'b0;
            si         <= 1'b0;
            chain_rn   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shadow     <= shadow_n;
            result_out <= result_n;
            se         <= state_n == LOAD || state_n == UNLOAD;
            si         <= si_n;
            chain_rn   <= state_n != CLEAR;
            busy       <= state_n != IDLE;
            done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench driving scan_chain_ctrl against a behavioural 16-flop scan chain
module tb_scan_chain_ctrl;
    logic CK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic [15:0] pattern_in = '0;
    logic so;
    logic se, si, chain_rn, busy, done;
    logic [15:0] result_out;
    logic [15:0] chain = '0;
    logic preload = 1'b0;
    int fm = 0;
    int n_assert = 0;
    int n_fail = 0;

    scan_chain_ctrl #(.CHAIN_LEN(16), .CNT_W(5)) dut (
        .CK(CK), .RST(RST), .start(start), .clr(clr), .pattern_in(pattern_in), .so(so),
        .se(se), .si(si), .chain_rn(chain_rn), .busy(busy), .done(done), .result_out(result_out)
    );

    always #5 CK = ~CK;
    assign so = chain[15];

    // functional D: 0 = hold, 1 = invert, 2 = constant zero
    always @(posedge CK) begin
        if (preload) chain <= '1;
        else if (!chain_rn) chain <= '0;
        else if (se) chain <= {chain[14:0], si};
        else chain <= fm == 1 ? ~chain : fm == 2 ? 16'h0000 : chain;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " se"}, 32'(se), 0);
        check({tag, " si"}, 32'(si), 0);
        check({tag, " chain_rn"}, 32'(chain_rn), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
    endtask

    task automatic run_seq(input logic [15:0] pat, input logic c_clr, input int mode,
                           input logic [15:0] exp_res, input bit poke, input int abort_at);
        int l0, dc;
        logic in_load, in_unl, exp_si;
        l0 = c_clr ? 2 : 1;
        dc = l0 + 33;
        fm = mode;
        start = 1'b1;
        clr = c_clr;
        pattern_in = pat;
        @(posedge CK);
        #1;
        start = 1'b0;
        clr = 1'b0;
        pattern_in = ~pat;
        for (int c = 1; c <= dc + 2; c++) begin
            in_load = c >= l0 && c < l0 + 16;
            in_unl = c >= l0 + 17 && c <= l0 + 32;
            exp_si = in_load ? pat[15 - (c - l0)] : 1'b0;
            check($sformatf("se c%0d", c), 32'(se), 32'(in_load || in_unl));
            check($sformatf("si c%0d", c), 32'(si), 32'(exp_si));
            check($sformatf("chain_rn c%0d", c), 32'(chain_rn), 32'(!(c_clr && c == 1)));
            check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= dc));
            check($sformatf("done c%0d", c), 32'(done), 32'(c == dc));
            if (c >= dc) check($sformatf("result c%0d", c), 32'(result_out), 32'(exp_res));
            if (abort_at == c) begin
                RST = 1'b1;
                @(posedge CK);
                #1;
                RST = 1'b0;
                check_idle("abort");
                check("abort result", 32'(result_out), 0);
                for (int k = 0; k < 40; k++) begin
                    @(posedge CK);
                    #1;
                    check($sformatf("abort done k%0d", k), 32'(done), 0);
                end
                return;
            end
            start = poke && (c == 5 || c == 20);
            if (poke && c == 5) pattern_in = 16'hFFFF;
            @(posedge CK);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge CK);
        #1;
        check_idle("reset");
        check("reset result", 32'(result_out), 0);
        RST = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        check_idle("idle");
        check("idle result", 32'(result_out), 0);

        run_seq(16'hA5C3, 1'b0, 0, 16'hA5C3, 1'b0, 0);
        run_seq(16'h00FF, 1'b0, 1, 16'hFF00, 1'b0, 0);

        preload = 1'b1;
        @(posedge CK);
        #1;
        preload = 1'b0;
        check("preload chain", 32'(chain), 32'hFFFF);
        run_seq(16'h0001, 1'b1, 2, 16'h0000, 1'b0, 0);

        run_seq(16'h1234, 1'b0, 0, 16'h1234, 1'b1, 0);
        check_idle("after poke");

        run_seq(16'h3C5A, 1'b0, 0, 16'h0000, 1'b0, 22);
        run_seq(16'h9E17, 1'b0, 1, 16'h61E8, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
